cnt_seq_ctrl: RTL

- Sequencer for the W-bit free-running up/down counter (`rst`, `mode`, `clk`; `mode=1` counts up, `mode=0` counts down; wraps mod 2^W; reset value 0).
- Accepts seek and bounce commands over a valid/ready port.
- Drives the counter's `rst` and `mode`, and watches its count value.
- Reports completion with a one-cycle done pulse and a status code.

---
 rtl/cnt_seq_pkg.sv | 9 +
 rtl/cnt_seq_watchdog.sv | 27 ++
 rtl/cnt_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared types and default sizing for the up/down counter sequencer.
package cnt_seq_pkg;
    localparam int W_DEF       = 10;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN, FINISH} state_e;
    typedef enum logic {SEEK, BOUNCE} op_e;
    typedef enum logic [1:0] {ST_OK, ST_ABORT, ST_TIMEOUT} status_e;
endpackage

// File: rtl/cnt_seq_watchdog.sv
// Run-time watchdog: counts enabled cycles after a clear and flags when TIMEOUT is reached.
module cnt_seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT));

    // Saturates at TIMEOUT so a stalled controller keeps seeing expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencer driving a free-running up/down counter through SEEK and BOUNCE commands.
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic [W-1:0] cmd_target,
    input  logic [3:0]   cmd_reps,
    input  logic         abort,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_rst,
    output logic         cnt_mode,
    output logic         busy,
    output logic         done,
    output logic [1:0]   done_status,
    output logic [1:0]   dbg_state
);
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    state_e       state, state_d;
    status_e      status_q, status_d;
    op_e          op_q;
    logic [W-1:0] tgt_q;
    logic [3:0]   reps_q, reps_d;
    logic         accept;
    logic         wd_en;
    logic         wd_expired;

    cnt_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            status_q <= ST_OK;
            op_q     <= SEEK;
            tgt_q    <= '0;
            reps_q   <= 4'd1;
        end else begin
            state    <= state_d;
            status_q <= status_d;
            reps_q   <= reps_d;
            if (accept) begin
                op_q  <= op_e'(cmd_op);
                tgt_q <= cmd_target;
            end
        end
    end

    // cnt_rst/cnt_mode react to cnt_q in the same cycle so the counter stops exactly on target.
    always_comb begin
        state_d  = state;
        status_d = status_q;
        reps_d   = reps_q;
        accept   = 1'b0;
        wd_en    = 1'b0;
        cnt_rst  = 1'b1;
        cnt_mode = 1'b1;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    reps_d = (cmd_reps == 4'd0) ? 4'd1 : cmd_reps;
                    if (cmd_op == BOUNCE || cmd_target <= HALF) state_d = RUN_UP;
                    else                                         state_d = RUN_DN;
                end
            end
            RUN_UP: begin
                cnt_rst = 1'b0;
                wd_en   = 1'b1;
                if (abort) begin
                    cnt_rst  = 1'b1;
                    status_d = ST_ABORT;
                    state_d  = FINISH;
                end else if (cnt_q == tgt_q) begin
                    if (op_q == SEEK || tgt_q == '0) begin
                        cnt_rst  = 1'b1;
                        status_d = ST_OK;
                        state_d  = FINISH;
                    end else begin
                        cnt_mode = 1'b0;
                        state_d  = RUN_DN;
                    end
                end else if (wd_expired) begin
                    cnt_rst  = 1'b1;
                    status_d = ST_TIMEOUT;
                    state_d  = FINISH;
                end
            end
            RUN_DN: begin
                cnt_rst  = 1'b0;
                cnt_mode = 1'b0;
                wd_en    = 1'b1;
                if (abort) begin
                    cnt_rst  = 1'b1;
                    status_d = ST_ABORT;
                    state_d  = FINISH;
                end else if ((op_q == SEEK && cnt_q == tgt_q) || (op_q == BOUNCE && cnt_q == '0)) begin
                    if (op_q == BOUNCE && reps_q > 4'd1) begin
                        cnt_mode = 1'b1;
                        reps_d   = reps_q - 4'd1;
                        state_d  = RUN_UP;
                    end else begin
                        cnt_rst  = 1'b1;
                        status_d = ST_OK;
                        state_d  = FINISH;
                    end
                end else if (wd_expired) begin
                    cnt_rst  = 1'b1;
                    status_d = ST_TIMEOUT;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state == RUN_UP) || (state == RUN_DN) || (state == FINISH);
    assign done        = (state == FINISH);
    assign done_status = (state == FINISH) ? status_q : ST_OK;
    assign dbg_state   = state;
endmodule
